ram_block_copier: RTL and testbench
===================================

RAM_BLOCK_COPIER -- requirements
Module: ram_block_copier

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- ADDR_W, 5, RAM word-address width (32 words).
- DATA_W, 32, RAM word width.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-high.
- start, in, 1, copy request.
- src_base, in, ADDR_W, first source word.
- dst_base, in, ADDR_W, first destination word.
- length, in, ADDR_W+1, word count.
- abort, in, 1, stop the copy early.
- busy, out, 1, copy in progress.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, one-cycle rejected-request pulse.
- words_done, out, ADDR_W+1, words written so far.
- checksum, out, DATA_W, sum of the words read.
- mem_address, out, ADDR_W, RAM address.
- mem_data_in, out, DATA_W, RAM write data.
- mem_data_out, in, DATA_W, RAM combinational read data.
- mem_writeOn, out, 1, RAM write strobe.

REQ-003 One clock and one reset SHALL be used; reset SHALL be asynchronous and active-high.

REQ-004 The block SHALL drive a combinational-read, level-write 32x32 RAM; every output SHALL come straight from a flop (no combinational paths to the RAM).

Function
REQ-005 The FSM SHALL have the states IDLE, READ, WRITE and DONE.

REQ-006 In IDLE, start=1 with 1<=length<=32 SHALL latch src_base, dst_base and length, clear words_done and checksum, and enter READ.
- The cycle after the start edge SHALL show busy=1.

REQ-007 In IDLE, start=1 with length=0 or length>32 SHALL pulse err for 1 cycle.
- The FSM SHALL stay in IDLE.
- No RAM write SHALL occur.
- words_done and checksum SHALL keep their values.

REQ-008 start SHALL be ignored while busy=1.

REQ-009 The READ state for word k SHALL present:
- mem_address=(src+k) mod 32.
- mem_writeOn=0.

REQ-010 On the edge leaving READ:
- hold SHALL be loaded with mem_data_out.
- checksum SHALL become checksum+mem_data_out, mod 2^DATA_W.

REQ-011 The WRITE state for word k SHALL present, stable for the whole cycle:
- mem_address=(dst+k) mod 32.
- mem_data_in=hold.
- mem_writeOn=1.

REQ-012 mem_writeOn SHALL be 1 only in WRITE and SHALL never be high while mem_address changes within a cycle.

REQ-013 On leaving WRITE, words_done SHALL increment.
- If words_done reaches the latched length, the FSM SHALL go to DONE; otherwise it SHALL go to READ for word k+1.

REQ-014 Timing: a start at edge t SHALL give:
- First READ at cycle t+1.
- Last WRITE at cycle t+2L.
- DONE at t+2L+1, with done=1 and busy=0.
- Return to IDLE on the next cycle.

REQ-015 Source and destination address counters SHALL wrap 31 to 0 independently.

REQ-016 Copies SHALL proceed in ascending order; overlapping ranges SHALL produce exactly the sequential read-then-write result.

REQ-017 abort=1 sampled in READ SHALL skip the pending write and go to DONE.

REQ-018 abort=1 sampled in WRITE SHALL complete that write and count it, then go to DONE.

REQ-019 If abort and the final WRITE coincide, done SHALL pulse once.

REQ-020 words_done and checksum SHALL hold their final values until the next accepted start.

Reset
REQ-021 reset=1 SHALL, asynchronously:
- Force IDLE.
- Set busy, done, err, mem_writeOn = 0.
- Set words_done, checksum, mem_address, mem_data_in, hold = 0.

REQ-022 Reset asserted mid-copy SHALL drop mem_writeOn without waiting for a clock edge; after reset the block SHALL accept a new start normally.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- RAM[0..3]=1,2,3,4; start src=0, dst=8, len=4 -> RAM[8..11]=1,2,3,4; done at cycle 9 after start; checksum=10; words_done=4.
- src=30, dst=2, len=4, RAM[30,31,0,1]=A,B,C,D -> RAM[2..5]=A,B,C,D; reads wrap at 31 to 0.
- start with len=0, then with len=33 -> err pulses each time; no mem_writeOn; busy stays 0.
- Overlap src=0, dst=1, len=3, RAM[0]=7 -> RAM[1..3]=7,7,7.
- abort in the 2nd READ of len=5 -> words_done=1; done pulse; only one write seen.
- reset asserted during a WRITE -> mem_writeOn=0 immediately; busy=0; a following len=1 copy succeeds.

Source files
------------

// File: rtl/ram_block_copier.sv
// Copies a block of words inside a single-port combinational-read RAM, one
// READ/WRITE cycle pair per word, with abort, error pulse and running checksum.
module ram_block_copier #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_writeOn
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  // Largest legal length is the full RAM depth.
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t              state;
  logic [ADDR_W-1:0]   src_ptr;
  logic [ADDR_W-1:0]   dst_ptr;
  logic [ADDR_W:0]     len_q;
  logic [DATA_W-1:0]   hold;
  logic                len_ok;
  logic [ADDR_W:0]     next_count;

  assign len_ok      = (length != '0) && (length <= MAX_LEN);
  assign next_count  = words_done + (ADDR_W+1)'(1);
  assign mem_data_in = hold;

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      mem_writeOn <= 1'b0;
      words_done  <= '0;
      checksum    <= '0;
      mem_address <= '0;
      hold        <= '0;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      len_q       <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              mem_address <= src_base;
              src_ptr     <= src_base + ADDR_W'(1);
              dst_ptr     <= dst_base;
              len_q       <= length;
              words_done  <= '0;
              checksum    <= '0;
              busy        <= 1'b1;
              state       <= READ;
            end else begin
              err <= 1'b1;
            end
          end
        end
        READ: begin
          hold     <= mem_data_out;
          checksum <= checksum + mem_data_out;
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            // Address and strobe change together on the edge, so the write
            // cycle sees a stable address for its whole duration.
            mem_address <= dst_ptr;
            dst_ptr     <= dst_ptr + ADDR_W'(1);
            mem_writeOn <= 1'b1;
            state       <= WRITE;
          end
        end
        WRITE: begin
          mem_writeOn <= 1'b0;
          words_done  <= next_count;
          if (abort || next_count == len_q) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mem_address <= src_ptr;
            src_ptr     <= src_ptr + ADDR_W'(1);
            state       <= READ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_block_copier.sv
// Self-checking bench: a RAM model, a sequential copy reference and a per-cycle
// compare process, driven by directed scenarios and randomized copies.
module tb_ram_block_copier;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic [AW:0]   length;
  logic          abort;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_done;
  logic [DW-1:0] checksum;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          mem_writeOn;

  logic [DW-1:0] ram [N];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Expected timeline of the copy in flight, in cycles after the start edge.
  bit mon_en       = 1'b0;
  int act_start    = -1000;
  int act_done_off = 0;
  int act_n        = 0;
  int err_cyc      = -1;
  int wr_count     = 0;
  int done_count   = 0;
  int last_done    = -1;
  logic [AW-1:0] exp_addr [N];
  logic [DW-1:0] exp_data [N];

  int            last_n   = 0;
  logic [DW-1:0] last_sum = '0;

  ram_block_copier #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .src_base(src_base),
    .dst_base(dst_base), .length(length), .abort(abort), .busy(busy),
    .done(done), .err(err), .words_done(words_done), .checksum(checksum),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_writeOn(mem_writeOn)
  );

  always #5 clk = ~clk;

  assign mem_data_out = ram[mem_address];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_writeOn) ram[mem_address] <= mem_data_in;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h", name, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    int   off;
    logic eb, ed, ew, ee;
    if (mon_en) begin
      off = cyc - act_start;
      eb  = (off >= 1) && (off < act_done_off);
      ed  = (off == act_done_off);
      ew  = (off >= 2) && (off <= 2 * act_n) && (off % 2 == 0);
      ee  = (cyc == err_cyc);
      if (mem_writeOn) wr_count++;
      if (done) begin
        done_count++;
        last_done = off;
      end
      check("ctrl{busy,done,we,err}", 64'({busy, done, mem_writeOn, err}), 64'({eb, ed, ew, ee}));
      if (ew) begin
        check("wr_addr", 64'(mem_address), 64'(exp_addr[(off-2)/2]));
        check("wr_data", 64'(mem_data_in), 64'(exp_data[(off-2)/2]));
      end
    end
  end

  // Reference: a plain sequential word-by-word copy; abort_at is the cycle
  // (after the start edge) in which abort is held high, 0 for none.
  task automatic run_copy(input int src, input int dst, input int len, input int abort_at);
    logic [DW-1:0] shadow [N];
    logic [DW-1:0] sum;
    logic [DW-1:0] v;
    int n, done_off, mism;
    bit rd_extra;
    shadow   = ram;
    rd_extra = 1'b0;
    if (abort_at >= 1 && abort_at <= 2 * len) begin
      if (abort_at % 2 == 1) begin
        n        = (abort_at - 1) / 2;
        rd_extra = 1'b1;
        done_off = 2 * n + 2;
      end else begin
        n        = abort_at / 2;
        done_off = 2 * n + 1;
      end
    end else begin
      n        = len;
      done_off = 2 * len + 1;
    end
    sum = '0;
    for (int i = 0; i < n; i++) begin
      v           = shadow[(src + i) % N];
      sum        += v;
      exp_addr[i] = AW'((dst + i) % N);
      exp_data[i] = v;
      shadow[(dst + i) % N] = v;
    end
    if (rd_extra) sum += shadow[(src + n) % N];

    wr_count   = 0;
    done_count = 0;
    src_base   = AW'(src);
    dst_base   = AW'(dst);
    length     = (AW+1)'(len);
    start      = 1'b1;
    @(posedge clk); #1;
    act_n        = n;
    act_done_off = done_off;
    act_start    = cyc - 1;
    for (int off = 1; off <= done_off + 1; off++) begin
      start = (off == 2) && (off < done_off);  // must be ignored while busy
      if (off == 2) length = '0;
      abort = (off == abort_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    check("words_done", 64'(words_done), 64'(n));
    check("checksum", 64'(checksum), 64'(sum));
    check("done_count", 64'(done_count), 64'd1);
    mism = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== shadow[i]) mism++;
    check("ram_contents_mismatches", 64'(mism), 64'd0);
    last_n   = n;
    last_sum = sum;
  endtask

  task automatic bad_start(input int len);
    src_base = AW'($urandom);
    dst_base = AW'($urandom);
    length   = (AW+1)'(len);
    start    = 1'b1;
    @(posedge clk); #1;
    err_cyc = cyc;
    start   = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("err_words_done_kept", 64'(words_done), 64'(last_n));
    check("err_checksum_kept", 64'(checksum), 64'(last_sum));
  endtask

  initial begin
    int src, dst, len, ab;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    src_base = '0; dst_base = '0; length = '0;
    for (int i = 0; i < N; i++) ram[i] = $urandom;
    #12;
    check("reset_outputs", 64'({busy, done, err, mem_writeOn}), 64'd0);
    check("reset_counters", 64'({words_done, checksum, mem_address, mem_data_in}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    ram[0] = 1; ram[1] = 2; ram[2] = 3; ram[3] = 4;
    run_copy(0, 8, 4, 0);
    for (int i = 0; i < 4; i++) check("basic_ram", 64'(ram[8+i]), 64'(i + 1));
    check("basic_checksum", 64'(checksum), 64'd10);
    check("basic_words_done", 64'(words_done), 64'd4);
    check("basic_done_latency", 64'(last_done), 64'd9);

    ram[30] = 32'hA0A0_0001; ram[31] = 32'hB0B0_0002;
    ram[0]  = 32'hC0C0_0003; ram[1]  = 32'hD0D0_0004;
    run_copy(30, 2, 4, 0);
    check("wrap_ram2", 64'(ram[2]), 64'h0000_0000_A0A0_0001);
    check("wrap_ram3", 64'(ram[3]), 64'h0000_0000_B0B0_0002);
    check("wrap_ram4", 64'(ram[4]), 64'h0000_0000_C0C0_0003);
    check("wrap_ram5", 64'(ram[5]), 64'h0000_0000_D0D0_0004);

    wr_count = 0;
    bad_start(0);
    bad_start(33);
    check("err_no_writes", 64'(wr_count), 64'd0);

    ram[0] = 7;
    run_copy(0, 1, 3, 0);
    for (int i = 1; i <= 3; i++) check("overlap_ram", 64'(ram[i]), 64'd7);

    run_copy(10, 20, 5, 3);
    check("abort_read_words_done", 64'(words_done), 64'd1);
    check("abort_read_writes", 64'(wr_count), 64'd1);

    run_copy(4, 12, 2, 4);
    check("abort_last_write_words", 64'(words_done), 64'd2);

    run_copy(31, 31, 32, 0);

    // Reset during the first WRITE of a 5-word copy.
    mon_en   = 1'b0;
    src_base = AW'(6); dst_base = AW'(16); length = (AW+1)'(5);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_write_strobe", 64'(mem_writeOn), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("reset_drops_strobe", 64'(mem_writeOn), 64'd0);
    check("reset_drops_busy", 64'(busy), 64'd0);
    check("reset_clears_count", 64'(words_done), 64'd0);
    @(posedge clk); #1;
    reset        = 1'b0;
    act_start    = -1000;
    act_done_off = 0;
    act_n        = 0;
    last_n       = 0;
    last_sum     = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    run_copy(9, 25, 1, 0);

    for (int t = 0; t < 12; t++) begin
      src = $urandom_range(0, N - 1);
      dst = $urandom_range(0, N - 1);
      len = $urandom_range(1, N);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * len) : 0;
      run_copy(src, dst, len, ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
